// File: rtl/vector_argmax_if.sv
`default_nettype none
// ============================================================================
// Module   : vector_argmax_if
// Brief    : PS control/status, y BRAM port and result bundle for vector_argmax.
// Revision : 1.0
// ============================================================================
interface vector_argmax_if #(
    parameter int ADDR_Y_SIZE = 12
);
    logic [31:0]            ps_control;
    logic [31:0]            pl_status;
    logic [ADDR_Y_SIZE-1:0] bram_addr_y;
    logic [31:0]            bram_rddata_y;
    logic [31:0]            bram_wrdata_y;
    logic [3:0]             bram_we_y;
    logic [15:0]            result_index;
    logic [31:0]            result_value;

    modport master (
        output ps_control,
        input  pl_status,
        input  bram_addr_y,
        output bram_rddata_y,
        input  bram_wrdata_y,
        input  bram_we_y,
        input  result_index,
        input  result_value
    );

    modport slave (
        input  ps_control,
        output pl_status,
        output bram_addr_y,
        input  bram_rddata_y,
        output bram_wrdata_y,
        output bram_we_y,
        output result_index,
        output result_value
    );
endinterface
`default_nettype wire

// File: rtl/vector_argmax.sv
`default_nettype none
// ============================================================================
// Module   : vector_argmax
// Brief    : Scans length_M floats in the y BRAM, reports the maximum and index.
// Revision : 1.0
// ============================================================================
module vector_argmax #(
    parameter int ADDR_Y_SIZE = 12,
    parameter int LENGTH_M    = 128
) (
    input  logic           clk,
    input  logic           reset,
    vector_argmax_if.slave bus
);
    localparam int                     CNT_W       = $clog2(LENGTH_M + 1);
    localparam logic [CNT_W-1:0]       c_len       = CNT_W'(LENGTH_M);
    localparam logic [15:0]            c_last_idx  = 16'(LENGTH_M - 1);
    localparam logic [ADDR_Y_SIZE-1:0] c_addr_step = ADDR_Y_SIZE'(4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [ADDR_Y_SIZE-1:0] r_addr;
    logic [CNT_W-1:0]       r_rd_cnt;
    logic [1:0]             r_vld;
    logic [15:0]            r_cmp_idx;
    logic                   r_fin;
    logic [31:0]            r_best_key;
    logic [15:0]            r_res_idx;
    logic [31:0]            r_res_val;
    logic                   w_start;
    logic                   w_issue;
    logic                   w_cmp;
    logic                   w_take;
    logic [31:0]            w_key;
    logic                   w_unused;

    assign w_start  = bus.ps_control[0];
    assign w_unused = &{1'b0, bus.ps_control[31:1]};
    assign w_issue  = (r_rd_cnt < c_len);
    assign w_cmp    = (r_state == S_SCAN) && r_vld[1];

    // Map float bits onto an unsigned total order: negatives inverted, positives get MSB set.
    assign w_key  = bus.bram_rddata_y[31] ? ~bus.bram_rddata_y
                                          : {1'b1, bus.bram_rddata_y[30:0]};
    assign w_take = w_cmp && ((r_cmp_idx == 16'd0) || (w_key > r_best_key));

    assign bus.pl_status     = {31'd0, (r_state == S_DONE)};
    assign bus.bram_addr_y   = r_addr;
    assign bus.bram_wrdata_y = 32'd0;
    assign bus.bram_we_y     = 4'd0;
    assign bus.result_index  = r_res_idx;
    assign bus.result_value  = r_res_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_SCAN;
            S_SCAN:  if (r_fin)   w_next = S_DONE;
            S_DONE:  if (!w_start) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // r_vld[0]: address on the bus is a live element; r_vld[1]: read data is live.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr     <= '0;
            r_rd_cnt   <= '0;
            r_vld      <= '0;
            r_cmp_idx  <= '0;
            r_fin      <= 1'b0;
            r_best_key <= '0;
            r_res_idx  <= '0;
            r_res_val  <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_start) begin
                r_addr     <= '0;
                r_rd_cnt   <= CNT_W'(1);
                r_vld      <= 2'b01;
                r_cmp_idx  <= '0;
                r_fin      <= 1'b0;
                r_best_key <= '0;
                r_res_idx  <= '0;
                r_res_val  <= '0;
            end
        end else if (r_state == S_SCAN) begin
            if (w_issue) begin
                r_addr   <= r_addr + c_addr_step;
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
            r_vld <= {r_vld[0], w_issue};
            if (w_cmp) begin
                r_cmp_idx <= r_cmp_idx + 16'd1;
                if (r_cmp_idx == c_last_idx) begin
                    r_fin <= 1'b1;
                end
            end
            if (w_take) begin
                r_best_key <= w_key;
                r_res_idx  <= r_cmp_idx;
                r_res_val  <= bus.bram_rddata_y;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vector_argmax.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_argmax
// Brief    : Randomized and directed scans of vector_argmax against a reference.
// Revision : 1.0
// ============================================================================
module tb_vector_argmax;
    localparam int ADDR_Y_SIZE = 12;
    localparam int LENGTH_M    = 128;
    localparam int LATENCY     = LENGTH_M + 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem [LENGTH_M];

    vector_argmax_if #(.ADDR_Y_SIZE(ADDR_Y_SIZE)) bus ();

    vector_argmax #(
        .ADDR_Y_SIZE (ADDR_Y_SIZE),
        .LENGTH_M    (LENGTH_M)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.bram_rddata_y <= mem[bus.bram_addr_y[8:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Numeric float ordering: positive beats negative, then magnitude (reversed for negatives).
    function automatic bit beats(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return !a[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    function automatic int argmax_prefix(input int n);
        int best = 0;
        for (int j = 1; j < n; j++) if (beats(mem[j], mem[best])) best = j;
        return best;
    endfunction

    // Reference: counts edges since start and derives every output from that count.
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    int          m_k      = 0;
    logic [11:0] m_addr   = '0;
    logic [15:0] m_idx    = '0;
    logic [31:0] m_val    = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 1'b0; m_done = 1'b0; m_k = 0;
            m_addr = '0; m_idx = '0; m_val = '0;
        end else if (!m_active) begin
            if (bus.ps_control[0]) begin
                m_active = 1'b1; m_done = 1'b0; m_k = 0;
                m_addr = '0; m_idx = '0; m_val = '0;
            end
        end else if (m_done) begin
            if (!bus.ps_control[0]) begin
                m_active = 1'b0; m_done = 1'b0;
            end
        end else begin
            m_k++;
            if (m_k <= LENGTH_M - 1) m_addr = 12'(4 * m_k);
            if (m_k >= 2 && m_k <= LENGTH_M + 1) begin
                int b;
                b = argmax_prefix(m_k - 1);
                m_idx = 16'(b);
                m_val = mem[b];
            end
            if (m_k == LENGTH_M + 2) m_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("pl_status", bus.pl_status, {31'd0, m_done});
        check("bram_addr_y", 32'(bus.bram_addr_y), 32'(m_addr));
        check("result_index", 32'(bus.result_index), 32'(m_idx));
        check("result_value", bus.result_value, m_val);
        check("bram_we_y", 32'(bus.bram_we_y), 32'd0);
        check("bram_wrdata_y", bus.bram_wrdata_y, 32'd0);
    end

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < LENGTH_M; i++) mem[i] = v;
    endtask

    task automatic do_scan(input string name, input bit drop_early, input int hold,
                           input bit has_exp, input logic [15:0] e_idx, input logic [31:0] e_val);
        int edges = 0;
        int a;
        @(negedge clk);
        bus.ps_control = $urandom | 32'd1;
        @(posedge clk);
        while (edges < LATENCY + 20) begin
            @(posedge clk);
            edges++;
            #1;
            if (bus.pl_status[0]) break;
            a = (edges < LENGTH_M - 1) ? edges : LENGTH_M - 1;
            check({name, " addr seq"}, 32'(bus.bram_addr_y), 32'(4 * a));
            if (drop_early && edges == 10) bus.ps_control = $urandom & 32'hFFFF_FFFE;
        end
        check({name, " latency"}, 32'(edges), 32'(LATENCY));
        if (has_exp) begin
            check({name, " index"}, 32'(bus.result_index), 32'(e_idx));
            check({name, " value"}, bus.result_value, e_val);
        end
        if (!drop_early) begin
            repeat (hold) begin
                @(posedge clk); #1;
                check({name, " done held"}, 32'(bus.pl_status[0]), 32'd1);
            end
            bus.ps_control = $urandom & 32'hFFFF_FFFE;
        end
        @(posedge clk); #1;
        check({name, " done fall"}, 32'(bus.pl_status[0]), 32'd0);
        repeat ($urandom_range(1, 4)) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pool [5];
        pool[0] = 32'h3F80_0000; pool[1] = 32'hBF80_0000; pool[2] = 32'h0000_0000;
        pool[3] = 32'h8000_0000; pool[4] = 32'h4000_0000;
        bus.ps_control = 32'd0;
        fill(32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset pl_status", bus.pl_status, 32'd0);
        check("reset addr", 32'(bus.bram_addr_y), 32'd0);
        check("reset index", 32'(bus.result_index), 32'd0);
        check("reset value", bus.result_value, 32'd0);
        #1 reset = 1'b1;

        mem[37] = 32'h42C8_0000;
        do_scan("single max", 1'b0, 0, 1'b1, 16'd37, 32'h42C8_0000);

        fill(32'hBF80_0000);
        mem[5] = 32'hC000_0000; mem[90] = 32'hBF00_0000;
        do_scan("negatives", 1'b0, 1, 1'b1, 16'd90, 32'hBF00_0000);

        fill(32'd0);
        mem[3] = 32'h4120_0000; mem[64] = 32'h4120_0000;
        do_scan("tie", 1'b1, 0, 1'b1, 16'd3, 32'h4120_0000);

        fill(32'hC120_0000);
        mem[0] = 32'h8000_0000; mem[1] = 32'h0000_0000;
        do_scan("zero sign", 1'b0, 0, 1'b1, 16'd1, 32'h0000_0000);

        do_scan("handshake 1", 1'b0, 3, 1'b1, 16'd1, 32'h0000_0000);
        do_scan("handshake 2", 1'b0, 3, 1'b1, 16'd1, 32'h0000_0000);

        // Reset mid-scan with a non-trivial partial result already registered.
        fill(32'd0);
        mem[20] = 32'h4100_0000;
        @(negedge clk);
        bus.ps_control = 32'd1;
        @(posedge clk);
        repeat (60) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset pl_status", bus.pl_status, 32'd0);
        check("midreset addr", 32'(bus.bram_addr_y), 32'd0);
        check("midreset index", 32'(bus.result_index), 32'd0);
        check("midreset value", bus.result_value, 32'd0);
        bus.ps_control = 32'd0;
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        fill(32'd0);
        mem[127] = 32'h4040_0000;
        do_scan("after reset", 1'b0, 0, 1'b1, 16'd127, 32'h4040_0000);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < LENGTH_M; i++) begin
                case (t % 3)
                    0: mem[i] = $urandom;
                    1: mem[i] = pool[$urandom_range(0, 4)];
                    default: mem[i] = $urandom | 32'h8000_0000;
                endcase
            end
            do_scan("random", t[0], int'($urandom_range(0, 4)), 1'b0, 16'd0, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vector_argmax.md
# vector_argmax

Downstream consumer of the matrix-vector multiplier's y buffer. After the multiplier finishes, the PS starts this block, which scans the length_M IEEE-754 single-precision y values in the y BRAM and reports the largest value and its index, i.e. the classifier's predicted class. Control and status follow the same ps_control/pl_status start/done handshake as the multiplier. The block is read-only on the y BRAM port.

## Interface
- addr_y_size, 12, byte-address width of the y BRAM port
- length_M, 128, number of y elements scanned (≥1, ≤ 2^(addr_y_size-2))
- clk  input  1  sole clock, all logic on rising edge
- reset  input  1  asynchronous, active-low; 0 forces reset state immediately
- ps_control  input  32  bit 0 = start; bits 31:1 ignored
- pl_status  output  32  bit 0 = done; bits 31:1 always 0
- bram_addr_y  output  addr_y_size  byte address; element i at 4*i
- bram_rddata_y  input  32  read data, valid one cycle after the address is sampled by the BRAM
- bram_wrdata_y  output  32  tied 0
- bram_we_y  output  4  tied 0
- result_index  output  16  index of maximum element, zero-extended
- result_value  output  32  raw float bits of maximum element

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: pl_status[0]=0. On an edge where ps_control[0]=1: bram_addr_y<=0, rd_cnt<=1, clear the compare-valid pipe, best_key<=0, result_index<=0, result_value<=0, go to SCAN.
- SCAN: each edge, bram_addr_y advances by 4 while rd_cnt<length_M (then holds). A 2-stage valid pipe tracks each issued address. When the element arrives at stage 2, form key = bits[31] ? ~bits : {1'b1, bits[30:0]}, then compare it unsigned with best_key.
- Update rule: if the element is index 0, or key > best_key (strict), load best_key, result_value and result_index with the element. Ties therefore keep the lowest index. +0 ranks above -0. NaNs are not special-cased and are ordered by key (positive NaN highest, negative NaN lowest).
- After element length_M-1 has been compared, go to DONE.
- DONE: pl_status[0]=1. Hold result_index and result_value. Return to IDLE on the first edge where ps_control[0]=0. If ps_control[0] is already 0 on entry, done is still high for exactly one cycle.
- ps_control[0] falling during SCAN is ignored and the scan completes.
- Start is level-sensitive. In IDLE, a start that is still high immediately after DONE→IDLE begins a new scan.
- result_index and result_value keep their last values in IDLE until the next start clears them.

## Timing
- All outputs reset to 0: pl_status, bram_addr_y, result_index, result_value, and state=IDLE.
- Let E0 be the edge on which start is sampled in IDLE:
  - bram_addr_y = 4*i during the cycle after edge E(i), for i<length_M.
  - Element i is compared at edge E(i+2).
  - The final result is registered at E(length_M+1).
  - pl_status[0] rises after E(length_M+2), which is 130 edges for length_M=128.
- One element is processed per cycle with no bubbles. bram_addr_y holds 4*(length_M-1) from then until the next start.
- Reset low at any time, including mid-SCAN or DONE:
  - The block returns to IDLE asynchronously and all outputs clear.
  - No partial result is retained.
  - Once reset is released, start is needed again.

## Test plan
- y all 0, except y[37]=0x42C80000 (100.0) → result_index=37, result_value=0x42C80000, pl_status[0] rising 130 edges after start.
- y[i]=0xBF800000 (-1.0) for all i, except y[5]=0xC0000000 (-2.0) and y[90]=0xBF000000 (-0.5) → index 90, value 0xBF000000.
- Ties: y[3]=y[64]=0x41200000 (10.0), others 0 → index 3. Zero signs: y[0]=0x80000000 (-0), y[1]=0x00000000 (+0), others 0xC1200000 → index 1.
- Handshake: hold ps_control=1 through done, drop it 3 cycles later → pl_status[0] falls on the following edge. Re-raise start → a second scan returns the same result with the same latency.
- Reset mid-scan: pull reset low at E60 → all outputs 0 immediately. Release reset and restart with y[127]=0x40400000 and the rest 0 → index 127, value 0x40400000.
- Throughout every test, bram_we_y=0, bram_wrdata_y=0, and bram_addr_y follows 0,4,…,508 on consecutive cycles.
